dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-through, no-write-allocate L1 data cache that answers the MEM stage's load/store requests and refills from the external memory bus. Load hits return data in the same cycle with no stall; misses and all stores hold `MCACHE_STALL_SM` high until the memory side completes. Bus errors are reported to MEM as a one-cycle `BUS_ERROR_SX`.

## Interface
- `LINES`, default 16: number of cache lines, a power of two; `IDX = log2(LINES)`.
- `WPL`, default 4: 32-bit words per line, a power of two; `WB = log2(WPL)`.
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `MCACHE_ADR_SM`  in  32  byte address
- `MCACHE_DATA_SM`  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- `MCACHE_ADR_VALID_SM`  in  1  request valid
- `MCACHE_LOAD_SM`  in  1  load request
- `MCACHE_STORE_SM`  in  1  store request
- `byt_sel`  in  4  byte lanes of the aligned word; 0000 means a misaligned or null access
- `MCACHE_RESULT_SM`  out  32  full aligned word; MEM performs lane extraction and sign extension
- `MCACHE_STALL_SM`  out  1  request not yet complete; MEM holds all inputs stable while this is high
- `BUS_ERROR_SX`  out  1  one-cycle pulse when a memory access errors
- `MEM_REQ`  out  1  memory request valid
- `MEM_WE`  out  1  1 = write, 0 = read
- `MEM_ADR`  out  32  word-aligned address
- `MEM_WDATA`  out  32  lane-aligned write data
- `MEM_BE`  out  4  write byte enables; 1111 on reads
- `MEM_ACK`  in  1  access complete
- `MEM_RDATA`  in  32  read data, valid with `MEM_ACK`
- `MEM_ERR`  in  1  error, valid with `MEM_ACK`

## Operation
- Address split: offset [1:0], word [WB+1:2], index [IDX+WB+1:WB+2], tag = the remaining upper bits.
- Storage: a `valid[LINES]` array in flops, reset asynchronously to 0. Tag and data arrays are flops with asynchronous read and are not reset.
- A request is active when `ADR_VALID & (LOAD | STORE) & byt_sel != 0`. If both LOAD and STORE are set, STORE wins.
- A request that is not active gives STALL = 0 and RESULT = 0. It generates no memory traffic and does not change the FSM.
- A hit requires `valid[index]` and a tag match.
- Store lane data is `MCACHE_DATA_SM << (8*ADR[1:0])`, driven on `MEM_WDATA`. `MEM_BE = byt_sel`.
- FSM states: IDLE, REFILL, WRITE, DONE, ERR.
  - IDLE, load hit: RESULT = the data word, STALL = 0, no state change.
  - IDLE, load miss: STALL = 1. Set `valid[index]` to 0, `cnt` to 0, latch tag and index, then go to REFILL.
  - IDLE, store: STALL = 1. Latch address, lane data and BE, then go to WRITE.
  - REFILL: STALL = 1, `MEM_REQ = 1`, `MEM_WE = 0`, `MEM_ADR = {tag, index, cnt, 2'b00}`.
    - On ACK without ERR: write `MEM_RDATA` into word `cnt` and increment `cnt`.
    - On ACK with `cnt == WPL-1`: write the tag, set valid, go to IDLE. The held load then hits.
    - On ACK with ERR: the line stays invalid; go to ERR.
  - WRITE: STALL = 1, `MEM_REQ = 1`, `MEM_WE = 1`.
    - On ACK without ERR: if the line hits (tag and valid re-checked), merge the BE lanes into the cached word. Go to DONE.
    - On ACK with ERR: the cache is not updated; go to ERR.
  - DONE: STALL = 0 for one cycle, so MEM consumes the store. Then go to IDLE.
  - ERR: STALL = 0, `BUS_ERROR_SX = 1`, RESULT = 0 for one cycle. Then go to IDLE.
- Memory handshake: `MEM_REQ` and all request fields stay constant until the cycle in which `MEM_ACK` is sampled high. `MEM_REQ` drops in the cycle after the last ACK. Only one access is outstanding at a time.

## Timing
- Reset values: all valid bits 0, FSM = IDLE, `cnt` = 0. `MEM_REQ`, `MEM_WE`, `BUS_ERROR_SX` are 0. `MEM_ADR`, `MEM_WDATA` are 0. `MEM_BE` is 1111. RESULT = 0. STALL follows the combinational request decode.
- Load hit latency: 0 cycles. RESULT and STALL are combinational from the request and the arrays.
- Load miss: `MEM_REQ` rises the cycle after the miss is presented. STALL drops `WPL + Σ(ACK wait)` cycles later, in the IDLE cycle following the last ACK.
- Store: at least 2 stalled cycles (IDLE, WRITE), then DONE with STALL = 0.
- `MEM_ACK` is ignored outside REFILL and WRITE.
- Reset asserted mid-refill or mid-write: return to IDLE immediately, all lines invalid, `MEM_REQ` = 0.
- The line being refilled is invalid from the miss cycle onward, so a partial refill never hits.

## Test plan
- Reset, then a load from 0x100: miss. `MEM_REQ` issues reads 0x100, 0x104, 0x108, 0x10C (ACK one cycle after each REQ). STALL is high until the last ACK + 1. RESULT = the word at 0x100.
- Load from 0x108 after the refill above: STALL = 0 in the same cycle; RESULT equals the refilled word 2; no `MEM_REQ`.
- Store byte 0xAB to 0x101 (`byt_sel` 0010) on a cached line: `MEM_WDATA` = 0x0000AB00, `MEM_BE` = 0010. After DONE, a load from 0x100 returns the old word with byte 1 = 0xAB.
- Store to an uncached address 0x400: write issued, no refill. A following load from 0x400 misses.
- Refill with `MEM_ERR` on the second ACK: ERR state, `BUS_ERROR_SX` pulses once with STALL = 0. A later load to the same line misses again.
- Load at 0x203 with `byt_sel` = 0000: STALL = 0, RESULT = 0, no memory traffic. Reset asserted during a WRITE leaves `MEM_REQ` = 0 and valid = 0.

Source files
------------

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits answer combinationally; misses refill a whole line, stores write through to memory.
module dcache #(
    parameter int LINES = 16,
    parameter int WPL   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] MCACHE_ADR_SM,
    input  logic [31:0] MCACHE_DATA_SM,
    input  logic        MCACHE_ADR_VALID_SM,
    input  logic        MCACHE_LOAD_SM,
    input  logic        MCACHE_STORE_SM,
    input  logic [3:0]  byt_sel,
    output logic [31:0] MCACHE_RESULT_SM,
    output logic        MCACHE_STALL_SM,
    output logic        BUS_ERROR_SX,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ERR
);
    localparam int IDX = $clog2(LINES);
    localparam int WB  = $clog2(WPL);
    localparam int TW  = 32 - IDX - WB - 2;
    localparam logic [WB-1:0] CNT_LAST = WB'(WPL - 1);

    typedef enum logic [2:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE, S_ERR} state_t;

    state_t         state_q, state_d;
    logic [WB-1:0]  cnt_q;
    logic [TW-1:0]  rtag_q;
    logic [IDX-1:0] ridx_q;
    logic [31:2]    wadr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wbe_q;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]  tag_q  [LINES];
    logic [31:0]    data_q [LINES][WPL];

    logic [TW-1:0]  req_tag;
    logic [IDX-1:0] req_idx;
    logic [WB-1:0]  req_word;
    logic [31:0]    lane_data;
    logic           req_active, req_store, req_hit;
    logic [TW-1:0]  wtag;
    logic [IDX-1:0] widx;
    logic [WB-1:0]  wword;
    logic           whit;
    logic [31:0]    merged;
    logic           refill_ok, refill_last, write_ok;

    assign req_tag    = MCACHE_ADR_SM[31:IDX+WB+2];
    assign req_idx    = MCACHE_ADR_SM[IDX+WB+1:WB+2];
    assign req_word   = MCACHE_ADR_SM[WB+1:2];
    assign lane_data  = MCACHE_DATA_SM << {MCACHE_ADR_SM[1:0], 3'b000};
    assign req_active = MCACHE_ADR_VALID_SM & (MCACHE_LOAD_SM | MCACHE_STORE_SM) & (|byt_sel);
    assign req_store  = MCACHE_STORE_SM;
    assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign wtag  = wadr_q[31:IDX+WB+2];
    assign widx  = wadr_q[IDX+WB+1:WB+2];
    assign wword = wadr_q[WB+1:2];
    assign whit  = valid_q[widx] && (tag_q[widx] == wtag);

    assign refill_ok   = (state_q == S_REFILL) && MEM_ACK && !MEM_ERR;
    assign refill_last = refill_ok && (cnt_q == CNT_LAST);
    assign write_ok    = (state_q == S_WRITE) && MEM_ACK && !MEM_ERR;

    always_comb begin
        merged = data_q[widx][wword];
        for (int b = 0; b < 4; b++)
            if (wbe_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_active) begin
                    if (req_store)     state_d = S_WRITE;
                    else if (!req_hit) state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (MEM_ACK) begin
                    if (MEM_ERR)                  state_d = S_ERR;
                    else if (cnt_q == CNT_LAST)   state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (MEM_ACK) state_d = MEM_ERR ? S_ERR : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MCACHE_RESULT_SM = '0;
        MCACHE_STALL_SM  = 1'b0;
        BUS_ERROR_SX     = 1'b0;
        MEM_REQ          = 1'b0;
        MEM_WE           = 1'b0;
        MEM_ADR          = '0;
        MEM_WDATA        = '0;
        MEM_BE           = 4'hF;
        case (state_q)
            S_IDLE: begin
                if (req_active) begin
                    if (!req_store && req_hit) MCACHE_RESULT_SM = data_q[req_idx][req_word];
                    else                       MCACHE_STALL_SM  = 1'b1;
                end
            end
            S_REFILL: begin
                MCACHE_STALL_SM = 1'b1;
                MEM_REQ         = 1'b1;
                MEM_ADR         = {rtag_q, ridx_q, cnt_q, 2'b00};
            end
            S_WRITE: begin
                MCACHE_STALL_SM = 1'b1;
                MEM_REQ         = 1'b1;
                MEM_WE          = 1'b1;
                MEM_ADR         = {wadr_q, 2'b00};
                MEM_WDATA       = wdata_q;
                MEM_BE          = wbe_q;
            end
            S_ERR:   BUS_ERROR_SX = 1'b1;
            default: ;
        endcase
    end

    // The missing line is invalidated at miss time so a partial refill can never hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            rtag_q  <= '0;
            ridx_q  <= '0;
            wadr_q  <= '0;
            wdata_q <= '0;
            wbe_q   <= 4'hF;
        end else begin
            if (state_q == S_IDLE && req_active) begin
                if (req_store) begin
                    wadr_q  <= MCACHE_ADR_SM[31:2];
                    wdata_q <= lane_data;
                    wbe_q   <= byt_sel;
                end else if (!req_hit) begin
                    valid_q[req_idx] <= 1'b0;
                    cnt_q            <= '0;
                    rtag_q           <= req_tag;
                    ridx_q           <= req_idx;
                end
            end
            if (refill_ok)   cnt_q           <= cnt_q + WB'(1);
            if (refill_last) valid_q[ridx_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_ok)   data_q[ridx_q][cnt_q] <= MEM_RDATA;
        if (refill_last) tag_q[ridx_q]         <= rtag_q;
        if (write_ok && whit) data_q[widx][wword] <= merged;
    end

endmodule

// File: tb/tb_dcache.sv
// Randomized bench for dcache: a line-level cache model plus a word-addressed memory model
// act as both the reference and the memory-side responder.
module tb_dcache;
    localparam int LINES = 16;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] adr, wdat;
    logic        avalid, ld, st;
    logic [3:0]  bsel;
    logic [31:0] result;
    logic        stall, buserr;
    logic        mem_req, mem_we;
    logic [31:0] mem_adr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack, mem_err;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dcache #(.LINES(LINES), .WPL(WPL)) dut (
        .clk(clk), .reset_n(reset_n),
        .MCACHE_ADR_SM(adr), .MCACHE_DATA_SM(wdat), .MCACHE_ADR_VALID_SM(avalid),
        .MCACHE_LOAD_SM(ld), .MCACHE_STORE_SM(st), .byt_sel(bsel),
        .MCACHE_RESULT_SM(result), .MCACHE_STALL_SM(stall), .BUS_ERROR_SX(buserr),
        .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_ADR(mem_adr), .MEM_WDATA(mem_wdata),
        .MEM_BE(mem_be), .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata), .MEM_ERR(mem_err)
    );

    always #5 clk = ~clk;

    // Reference state: cache contents per line and backing memory per word address.
    bit          mv    [LINES];
    logic [31:0] mtag  [LINES];
    logic [31:0] mline [LINES][WPL];
    logic [31:0] mem   [logic [31:0]];

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
    } op_t;
    op_t expq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % WPL);
    endfunction

    // Drives one MEM-stage request to completion while playing the memory side.
    task automatic access(input logic v, input logic l, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] bs, input int err_at);
        int li, wd, cyc, waits, wl, nops, exp_stall;
        logic [31:0] tg, exp_res, rd, m;
        bit active, is_load, err_seen;
        li = line_of(a);
        wd = word_of(a);
        tg = a >> 8;
        active = v && (l || s) && (bs != 4'b0000);
        is_load = active && !s;
        exp_res = 32'h0;
        expq.delete();
        if (active && s) begin
            expq.push_back('{adr: a & ~32'h3, we: 1'b1, wdata: d << (8 * (a % 4)),
                             be: bs, err: (err_at == 0)});
        end else if (is_load) begin
            if (mv[li] && mtag[li] == tg) begin
                exp_res = mline[li][wd];
            end else begin
                mv[li] = 1'b0;
                for (int k = 0; k < WPL; k++) begin
                    expq.push_back('{adr: {a[31:4], 4'b0000} + 32'(4 * k), we: 1'b0,
                                     wdata: 32'h0, be: 4'hF, err: (err_at == k)});
                    if (err_at == k) break;
                end
            end
        end
        nops = expq.size();
        exp_stall = (nops > 0) ? nops + 1 : 0;

        adr = a; wdat = d; avalid = v; ld = l; st = s; bsel = bs;
        if (!active) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
        end
        cyc = 0; waits = 0; wl = -1; err_seen = 1'b0;
        while (1) begin
            #1;
            if (!stall) break;
            if (cyc >= 100) begin
                chk("timeout", 32'(cyc), 32'(exp_stall));
                break;
            end
            cyc++;
            if (mem_req) begin
                if (expq.size() == 0) begin
                    chk("extra_req", mem_adr, 32'hFFFF_FFFF);
                end else begin
                    chk("mem_adr", mem_adr, expq[0].adr);
                    chk("mem_we", 32'(mem_we), 32'(expq[0].we));
                    chk("mem_be", 32'(mem_be), 32'(expq[0].be));
                    if (expq[0].we) chk("mem_wdata", mem_wdata, expq[0].wdata);
                    if (wl < 0) begin
                        wl = $urandom_range(0, 2);
                        waits += wl;
                    end
                    if (wl == 0) begin
                        mem_ack = 1'b1;
                        mem_err = expq[0].err;
                        err_seen = expq[0].err;
                        if (expq[0].we) begin
                            mem_rdata = $urandom;
                            if (!expq[0].err) begin
                                m = memrd(expq[0].adr);
                                for (int b = 0; b < 4; b++)
                                    if (expq[0].be[b]) m[8*b +: 8] = expq[0].wdata[8*b +: 8];
                                mem[expq[0].adr] = m;
                                if (mv[li] && mtag[li] == tg) mline[li][wd] = m;
                            end
                        end else begin
                            rd = memrd(expq[0].adr);
                            mem_rdata = rd;
                            if (!expq[0].err) begin
                                mline[li][word_of(expq[0].adr)] = rd;
                                if (word_of(expq[0].adr) == WPL - 1) begin
                                    mv[li] = 1'b1;
                                    mtag[li] = tg;
                                end
                            end
                        end
                        void'(expq.pop_front());
                        wl = -1;
                    end else begin
                        wl--;
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_err = 1'b0;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(cyc), 32'(exp_stall + waits));
        chk("ops_left", 32'(expq.size()), 32'h0);
        chk("bus_error", 32'(buserr), 32'(err_seen));
        if (is_load && nops > 0 && !err_seen) exp_res = mline[li][wd];
        if (!active || is_load || err_seen) chk("result", result, exp_res);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        mem_err = 1'b0;
        avalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rb;
        logic        rl, rs;
        int          sel, rerr;

        reset_n = 1'b0;
        adr = 0; wdat = 0; avalid = 0; ld = 0; st = 0; bsel = 0;
        mem_ack = 0; mem_err = 0; mem_rdata = 0;
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_buserr", 32'(buserr), 0);
        chk("rst_adr", mem_adr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", 32'(mem_be), 32'hF);
        chk("rst_result", result, 0);
        chk("rst_stall", 32'(stall), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        access(1, 1, 0, 32'h100, 0, 4'hF, -1);        // miss, full refill
        access(1, 1, 0, 32'h108, 0, 4'hF, -1);        // hit on refilled line
        access(1, 0, 1, 32'h101, 32'hAB, 4'b0010, -1); // byte store to cached line
        access(1, 1, 0, 32'h100, 0, 4'hF, -1);        // merged byte visible
        access(1, 0, 1, 32'h400, 32'h1234_5678, 4'hF, -1);
        access(1, 1, 0, 32'h400, 0, 4'hF, -1);        // no-write-allocate: misses
        access(1, 1, 0, 32'h800, 0, 4'hF, 1);         // error on second refill beat
        access(1, 1, 0, 32'h800, 0, 4'hF, -1);        // line still invalid: misses again
        access(1, 1, 0, 32'h203, 0, 4'b0000, -1);     // null access
        access(1, 1, 1, 32'h104, 32'hCAFE_F00D, 4'hF, -1); // store wins over load
        access(1, 0, 1, 32'h10C, 32'h55, 4'hF, 0);    // store bus error
        access(1, 1, 0, 32'h10C, 0, 4'hF, -1);

        for (int n = 0; n < 300; n++) begin
            ra = 32'($urandom_range(0, 1023));
            sel = $urandom_range(0, 7);
            rl = (sel == 1) || (sel >= 5);
            rs = (sel >= 1) && (sel <= 4);
            rb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            rerr = ($urandom_range(0, 15) == 0) ? $urandom_range(0, rs ? 0 : WPL - 1) : -1;
            access(($urandom_range(0, 9) != 0), rl, rs, ra, $urandom, rb, rerr);
        end

        // Reset in the middle of a write-through store.
        access(1, 1, 0, 32'h100, 0, 4'hF, -1);
        adr = 32'h100; wdat = 32'h77; avalid = 1; ld = 0; st = 1; bsel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("mid_write_req", 32'(mem_req), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(mem_req), 0);
        chk("rst_mid_buserr", 32'(buserr), 0);
        avalid = 0;
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        access(1, 1, 0, 32'h100, 0, 4'hF, -1);        // all lines invalid: misses

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
